// File: rtl/common.sv
// Shared types and constants for the magic service-mode controller and its bus neighbours.
package common;

    typedef enum logic [1:0] {
        MACHINE_S48  = 2'd0,
        MACHINE_S128 = 2'd1,
        MACHINE_S3   = 2'd2,
        MACHINE_PENT = 2'd3
    } machine_t;

    typedef enum logic [1:0] {
        IDLE,
        NMI_REQ,
        MAPPED,
        EXIT_PEND
    } magic_state_t;

    typedef struct packed {
        logic        ioreq;
        logic        mreq;
        logic        m1;
        logic        rd;
        logic        wr;
        logic [15:0] a_reg;
        logic [7:0]  d_reg;
    } cpu_bus;

    localparam logic [7:0]  MAGIC_PORT          = 8'hF7;
    localparam logic [7:0]  MAGIC_SEL_EXIT      = 8'h00;
    localparam logic [7:0]  MAGIC_SEL_MACHINE   = 8'h01;
    localparam logic [7:0]  MAGIC_SEL_KEMPSTON  = 8'h02;
    localparam logic [7:0]  MAGIC_SEL_SINCLAIR  = 8'h03;
    localparam logic [7:0]  MAGIC_SEL_REBOOT    = 8'h04;
    localparam logic [15:0] NMI_VECTOR          = 16'h0066;

    function automatic logic [7:0] magic_readback(
        input logic [7:0] sel,
        input machine_t   m,
        input logic       kemp,
        input logic       sinc
    );
        case (sel)
            MAGIC_SEL_MACHINE:  return {6'b0, m};
            MAGIC_SEL_KEMPSTON: return {7'b0, kemp};
            MAGIC_SEL_SINCLAIR: return {7'b0, sinc};
            default:            return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/debounce.sv
// Button synchronizer and saturating debounce counter; emits one pulse per stable press.
module debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 280000
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (!sync[1])
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            // Fires only on the step into saturation, so a held button re-arms only after release.
            press <= sync[1] && (cnt == CNT_MAX - 1'b1);
        end
    end

endmodule

// File: rtl/magic_ctrl.sv
// Magic service mode: NMI request on a debounced press, firmware mapping from the 0x0066
// fetch until a firmware exit/reboot, and the config port that is only visible while mapped.
module magic_ctrl
    import common::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 280000,
    parameter int unsigned NMI_TIMEOUT     = 65535
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  cpu_bus     bus,
    input  logic       magic_button,
    output logic       n_nmi,
    output logic       magic_map,
    output logic       magic_reboot,
    output machine_t   machine,
    output logic       en_kempston,
    output logic       en_sinclair,
    output logic [7:0] d_out,
    output logic       d_out_active
);

    localparam int unsigned   TW       = $clog2(NMI_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(NMI_TIMEOUT - 1);

    magic_state_t  state, state_nx;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nx;
    logic          press;
    logic          nmi_fetch, seq_fetch;
    logic          port_hit, wr_dec, wr_dec_q, wr_stb, rd_dec;
    logic [7:0]    sel;
    logic          unused_bus;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk28 (clk28),
        .rst_n (rst_n),
        .btn   (magic_button),
        .press (press)
    );

    assign magic_map  = (state == MAPPED) || (state == EXIT_PEND);
    assign n_nmi      = (state != NMI_REQ);

    assign sel        = bus.a_reg[15:8];
    assign port_hit   = bus.ioreq && (bus.a_reg[7:0] == MAGIC_PORT) && magic_map;
    assign wr_dec     = port_hit && bus.wr;
    assign rd_dec     = port_hit && bus.rd;
    assign wr_stb     = wr_dec && !wr_dec_q;
    assign nmi_fetch  = bus.m1 && bus.mreq && bus.rd && (bus.a_reg == NMI_VECTOR);
    assign seq_fetch  = bus.m1 && bus.mreq && !wr_dec;
    assign unused_bus = ^bus.d_reg[7:2];

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= tmo_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        tmo_cnt_nx = '0;
        case (state)
            IDLE:
                if (press) state_nx = NMI_REQ;
            NMI_REQ:
                if (nmi_fetch)
                    state_nx = MAPPED;
                else if (tmo_cnt == TMO_LAST)
                    state_nx = IDLE;
                else
                    tmo_cnt_nx = tmo_cnt + 1'b1;
            MAPPED:
                if (wr_stb && sel == MAGIC_SEL_EXIT) state_nx = EXIT_PEND;
            EXIT_PEND:
                if (seq_fetch) state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
        // Reboot can only be strobed while mapped and overrides any exit in progress.
        if (wr_stb && sel == MAGIC_SEL_REBOOT) state_nx = IDLE;
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wr_dec_q     <= 1'b0;
            magic_reboot <= 1'b0;
            machine      <= MACHINE_PENT;
            en_kempston  <= 1'b1;
            en_sinclair  <= 1'b1;
            d_out        <= '0;
            d_out_active <= 1'b0;
        end else begin
            wr_dec_q     <= wr_dec;
            magic_reboot <= wr_stb && (sel == MAGIC_SEL_REBOOT);
            if (wr_stb) begin
                case (sel)
                    MAGIC_SEL_MACHINE:  machine     <= machine_t'(bus.d_reg[1:0]);
                    MAGIC_SEL_KEMPSTON: en_kempston <= bus.d_reg[0];
                    MAGIC_SEL_SINCLAIR: en_sinclair <= bus.d_reg[0];
                    default: ;
                endcase
            end
            d_out_active <= rd_dec;
            d_out        <= rd_dec ? magic_readback(sel, machine, en_kempston, en_sinclair) : '0;
        end
    end

endmodule

// File: tb/tb_magic_ctrl.sv
// Directed-vector bench for magic_ctrl with short debounce and NMI timeout.
module tb_magic_ctrl;
    import common::*;

    logic       clk28 = 1'b0;
    logic       rst_n;
    cpu_bus     bus;
    logic       magic_button;
    logic       n_nmi, magic_map, magic_reboot;
    machine_t   machine;
    logic       en_kempston, en_sinclair;
    logic [7:0] d_out;
    logic       d_out_active;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    magic_ctrl #(.DEBOUNCE_CYCLES(16), .NMI_TIMEOUT(64)) dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .bus          (bus),
        .magic_button (magic_button),
        .n_nmi        (n_nmi),
        .magic_map    (magic_map),
        .magic_reboot (magic_reboot),
        .machine      (machine),
        .en_kempston  (en_kempston),
        .en_sinclair  (en_sinclair),
        .d_out        (d_out),
        .d_out_active (d_out_active)
    );

    always #5 clk28 = ~clk28;

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".n_nmi"}, n_nmi, 1);
        chk({tag, ".map"}, magic_map, 0);
        chk({tag, ".reboot"}, magic_reboot, 0);
        chk({tag, ".machine"}, machine, 3);
        chk({tag, ".kemp"}, en_kempston, 1);
        chk({tag, ".sinc"}, en_sinclair, 1);
        chk({tag, ".d_out"}, d_out, 0);
        chk({tag, ".d_act"}, d_out_active, 0);
    endtask

    // Press lands on edge 18, FSM reacts on edge 19.
    task automatic press_button(input logic expect_nmi, input string tag);
        magic_button = 1'b1;
        repeat (18) tick();
        chk({tag, ".pre"}, n_nmi, 1);
        tick();
        chk({tag, ".post"}, n_nmi, expect_nmi ? 0 : 1);
        magic_button = 1'b0;
        repeat (3) tick();
        chk({tag, ".held"}, n_nmi, expect_nmi ? 0 : 1);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        bus = '0;
        bus.ioreq = 1'b1; bus.wr = 1'b1; bus.a_reg = a; bus.d_reg = d;
        tick();
        bus = '0;
        tick();
    endtask

    task automatic io_read(input logic [15:0] a, input logic [7:0] exp_d, input logic exp_act, input string tag);
        bus = '0;
        bus.ioreq = 1'b1; bus.rd = 1'b1; bus.a_reg = a;
        tick();
        chk({tag, ".d_out"}, d_out, exp_d);
        chk({tag, ".d_act"}, d_out_active, exp_act);
        bus = '0;
        tick();
        chk({tag, ".d_act_off"}, d_out_active, 0);
    endtask

    task automatic m1_fetch(input logic [15:0] a);
        bus = '0;
        bus.m1 = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1; bus.a_reg = a;
    endtask

    initial begin
        rst_n = 1'b1;
        bus = '0;
        magic_button = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("rst_rel");

        // Short press: 10 clocks high never reaches the count
        magic_button = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("short_hi", n_nmi, 1);
        end
        magic_button = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            chk("short_lo", n_nmi, 1);
        end

        // Long press held 40 clocks, no fetch: NMI low edges 19..82, then timeout
        magic_button = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            tick();
            chk($sformatf("long_nmi_%0d", i), n_nmi, (i >= 19 && i <= 82) ? 0 : 1);
            chk("long_map", magic_map, 0);
            if (i == 40) magic_button = 1'b0;
        end

        // NMI then fetches: 0x0038 ignored, 0x0066 maps on the same edge
        press_button(1'b1, "press1");
        m1_fetch(16'h0038);
        tick();
        chk("f38_nmi", n_nmi, 0);
        chk("f38_map", magic_map, 0);
        m1_fetch(16'h0066);
        tick();
        chk("f66_nmi", n_nmi, 1);
        chk("f66_map", magic_map, 1);
        bus = '0;
        tick();

        // Machine write with wr held 5 clocks; data changes mid-strobe must not apply
        bus.ioreq = 1'b1; bus.wr = 1'b1; bus.a_reg = 16'h01F7; bus.d_reg = 8'h02;
        tick();
        chk("wr_mach_first", machine, 2);
        bus.d_reg = 8'h01;
        repeat (4) tick();
        chk("wr_mach_once", machine, 2);
        bus = '0;
        tick();

        io_read(16'h01F7, 8'h02, 1'b1, "rd_mach");
        io_write(16'h02F7, 8'h00);
        chk("wr_kemp", en_kempston, 0);
        io_read(16'h02F7, 8'h00, 1'b1, "rd_kemp");
        io_read(16'h03F7, 8'h01, 1'b1, "rd_sinc");
        io_read(16'h55F7, 8'hFF, 1'b1, "rd_other");
        io_write(16'h07F7, 8'h00);
        chk("wr_other_mach", machine, 2);
        chk("wr_other_map", magic_map, 1);

        // Second press while mapped is ignored
        press_button(1'b0, "press_mapped");
        chk("press_mapped_map", magic_map, 1);

        // Exit: map held through the write and until the next m1 fetch
        bus.ioreq = 1'b1; bus.wr = 1'b1; bus.a_reg = 16'h00F7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("exit_wr_map", magic_map, 1);
        end
        bus = '0;
        tick();
        chk("exit_idle_map", magic_map, 1);
        m1_fetch(16'h1234);
        tick();
        chk("exit_fetch_map", magic_map, 0);
        bus = '0;
        tick();

        // Port invisible when unmapped
        io_write(16'h01F7, 8'h00);
        chk("unmap_wr", machine, 2);
        io_read(16'h01F7, 8'h00, 1'b0, "unmap_rd");

        // Remap and reboot
        press_button(1'b1, "press2");
        m1_fetch(16'h0066);
        tick();
        chk("remap", magic_map, 1);
        bus = '0;
        tick();
        bus.ioreq = 1'b1; bus.wr = 1'b1; bus.a_reg = 16'h04F7;
        tick();
        chk("reboot_pulse", magic_reboot, 1);
        chk("reboot_map", magic_map, 0);
        tick();
        chk("reboot_end", magic_reboot, 0);
        chk("reboot_kemp", en_kempston, 0);
        chk("reboot_mach", machine, 2);
        bus = '0;
        tick();

        // Async reset mid NMI request
        press_button(1'b1, "press3");
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk_reset_vals("arst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/magic_ctrl.md
Name: magic_ctrl

Overview:
- Controls "magic" service mode in the Spectrum core: debounces the magic button, requests NMI, maps firmware on the 0x0066 NMI fetch, and unmaps on firmware request.
- While mapped, owns the config port that sets machine type and joystick options for the I/O port decoder and memory mapper.
- Drives `magic_map` to both of those blocks.
- Sits between the CPU bus and the port decoder, on clk28.

Parameters:
- DEBOUNCE_CYCLES, 280000, clocks `magic_button` must stay stably high before it counts as a press (10 ms at 28 MHz).
- NMI_TIMEOUT, 65535, maximum clocks `n_nmi` is held low waiting for the 0x0066 fetch.

Ports:
- clk28  in  1  system clock, 28 MHz
- rst_n  in  1  asynchronous active-low reset
- bus  in  cpu_bus  uses ioreq, mreq, m1, rd, wr, a_reg[15:0], d_reg[7:0]
- magic_button  in  1  raw asynchronous button, active high
- n_nmi  out  1  NMI request to CPU, active low
- magic_map  out  1  firmware mapped
- magic_reboot  out  1  one-clock reboot pulse
- machine  out  machine_t  selected machine
- en_kempston  out  1  Kempston joystick enable
- en_sinclair  out  1  Sinclair joystick mapping enable
- d_out  out  8  config readback data
- d_out_active  out  1  `d_out` valid, for the bus mux

Behaviour:
- **Reset values:** n_nmi=1, magic_map=0, magic_reboot=0, machine=MACHINE_PENT, en_kempston=1, en_sinclair=1, d_out=0, d_out_active=0, state=IDLE, all counters 0.
- **Async reset:** asserting rst_n at any point, including mid-NMI or while mapped, restores these values immediately.
- **Button path:**
  - 2-flop synchronizer into the debounce counter.
  - Counter clears whenever the synced input is 0, otherwise saturates at DEBOUNCE_CYCLES.
  - A press event is a one-clock pulse when the counter reaches DEBOUNCE_CYCLES. Holding the button gives exactly one event; the button must be released to re-arm.
- **FSM states:** IDLE, NMI_REQ, MAPPED, EXIT_PEND.
  - IDLE: on a press event -> NMI_REQ; n_nmi=0 from the next clock; timeout counter cleared.
  - NMI_REQ:
    - Fetch detect: m1 && mreq && rd && a_reg==16'h0066. On detect -> MAPPED; on the same edge n_nmi=1 and magic_map=1.
    - If the timeout counter reaches NMI_TIMEOUT first -> IDLE with n_nmi=1.
  - MAPPED: magic_map=1. Press events are ignored.
  - EXIT_PEND:
    - magic_map stays 1 until the first clock where m1 && mreq is sampled after the exit write strobe has dropped.
    - On that clock -> IDLE with magic_map=0 from the next edge. That opcode fetch comes from the normal map.
- **Config write:**
  - Decode: ioreq && wr && a_reg[7:0]==8'hF7 && magic_map.
  - Acts once per bus cycle, on the rising edge of the decode (previous-cycle flop). This guarantees one action per OUT regardless of strobe length.
  - Selector a_reg[15:8]:
    - 00 = exit (MAPPED -> EXIT_PEND).
    - 01 = machine <= d_reg[1:0].
    - 02 = en_kempston <= d_reg[0].
    - 03 = en_sinclair <= d_reg[0].
    - 04 = reboot: magic_reboot=1 for exactly one clock; state -> IDLE and magic_map=0 next edge; config registers retained.
    - Other selectors are ignored.
- **Config read:**
  - d_out_active is registered one clock from ioreq && rd && a_reg[7:0]==8'hF7 && magic_map, the same latency as other port readers.
  - d_out by selector: 01 -> {6'b0, machine}; 02 -> {7'b0, en_kempston}; 03 -> {7'b0, en_sinclair}; other -> 8'hFF.
- **Outside magic_map:** port F7 is neither decoded nor driven.
- **Simultaneous events:** a press event during NMI_REQ, MAPPED or EXIT_PEND is discarded, not queued. Writes during EXIT_PEND are still accepted (magic_map is still 1).

Decomposition:
- Package `common` holds:
  - `machine_t`, 2 bits: MACHINE_S48=0, MACHINE_S128=1, MACHINE_S3=2, MACHINE_PENT=3.
  - MAGIC_PORT = 8'hF7.
  - Selector constants MAGIC_SEL_EXIT/MACHINE/KEMPSTON/SINCLAIR/REBOOT.
  - NMI_VECTOR = 16'h0066.
- One natural sub-module: `debounce` (synchronizer plus saturating counter plus press-pulse), parameterised by DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=16, NMI_TIMEOUT=64):
- Button high 10 clocks then low -> no n_nmi. Button high 40 clocks -> n_nmi=0 one clock after the count reaches 16; exactly one NMI request.
- NMI_REQ, then M1 fetch at 0x0066 -> n_nmi=1 and magic_map=1 on the same edge. A fetch at 0x0038 instead changes nothing.
- NMI_REQ with no fetch -> n_nmi returns to 1 after 64 clocks; state IDLE; magic_map stays 0.
- Mapped:
  - OUT (0x01F7),0x02 with wr held 5 clocks -> machine=MACHINE_S3, written once.
  - IN (0x01F7) -> d_out=8'h02 and d_out_active=1 one clock after the rd decode.
  - The same IN/OUT with magic_map=0 -> no effect, d_out_active=0.
- Mapped, OUT (0x00F7) -> magic_map held through the write. It drops on the edge after the next m1&&mreq sample. A second button press while mapped is ignored.
- Mapped, OUT (0x04F7) -> magic_reboot high exactly 1 clock, magic_map=0 next edge, en_kempston unchanged. rst_n pulsed while in NMI_REQ -> n_nmi=1, outputs at reset values.
